// File: rtl/fpu_job_issuer.sv
// fpu_job_issuer: buffers FPU jobs (op id + four memory handles) in a small
// FIFO and issues them one at a time to the FPU with a start/done handshake.
// NOOP jobs retire locally; undefined op codes raise a sticky error flag.
module fpu_job_issuer #(
    parameter int DEPTH    = 4,
    parameter int HANDLE_W = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [5:0]                  job_op,
    input  logic [HANDLE_W-1:0]         job_a,
    input  logic [HANDLE_W-1:0]         job_b,
    input  logic [HANDLE_W-1:0]         job_c,
    input  logic [HANDLE_W-1:0]         job_d,
    output logic [5:0]                  fpu_op,
    output logic [HANDLE_W-1:0]         fpu_a,
    output logic [HANDLE_W-1:0]         fpu_b,
    output logic [HANDLE_W-1:0]         fpu_c,
    output logic [HANDLE_W-1:0]         fpu_d,
    output logic                        fpu_start,
    input  logic                        fpu_done,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      queue_count,
    output logic [15:0]                 jobs_done,
    output logic                        err_op
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int JOB_W = 6 + 4 * HANDLE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Ops 1..17 are real FPU operations; 0 is NOOP; 18..63 are undefined.
    function automatic logic op_is_fpu(input logic [5:0] op);
        return (op >= 6'd1) && (op <= 6'd17);
    endfunction

    function automatic logic op_is_noop(input logic [5:0] op);
        return (op == 6'd0);
    endfunction

    logic [JOB_W-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    state_t              state_r;
    state_t              state_s;

    logic                push_s;
    logic                pop_s;
    logic [JOB_W-1:0]    head_s;
    logic [5:0]          head_op_s;
    logic                retire_s;

    logic [5:0]          fpu_op_r;
    logic [HANDLE_W-1:0] fpu_a_r;
    logic [HANDLE_W-1:0] fpu_b_r;
    logic [HANDLE_W-1:0] fpu_c_r;
    logic [HANDLE_W-1:0] fpu_d_r;
    logic                fpu_start_r;
    logic [15:0]         jobs_done_r;
    logic                err_op_r;

    // FIFO handshake, head decode and retirement strobe.
    always_comb begin
        push_s    = job_valid && (count_r < CNT_W'(DEPTH));
        pop_s     = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}});
        head_s    = mem_r[rd_ptr_r];
        head_op_s = head_s[JOB_W-1 -: 6];
        // A NOOP retires at its pop; an FPU job retires on done while waiting.
        if (pop_s && op_is_noop(head_op_s)) begin
            retire_s = 1'b1;
        end else if ((state_r == ST_WAIT) && fpu_done) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Job storage: entries are written on push only, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {job_op, job_a, job_b, job_c, job_d};
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: only defined FPU ops leave IDLE; START lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s && op_is_fpu(head_op_s)) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Presented job: captured on the pop edge and held until the next pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_op_r <= 6'd0;
            fpu_a_r  <= {HANDLE_W{1'b0}};
            fpu_b_r  <= {HANDLE_W{1'b0}};
            fpu_c_r  <= {HANDLE_W{1'b0}};
            fpu_d_r  <= {HANDLE_W{1'b0}};
        end else if (pop_s) begin
            {fpu_op_r, fpu_a_r, fpu_b_r, fpu_c_r, fpu_d_r} <= head_s;
        end else begin
            fpu_op_r <= fpu_op_r;
            fpu_a_r  <= fpu_a_r;
            fpu_b_r  <= fpu_b_r;
            fpu_c_r  <= fpu_c_r;
            fpu_d_r  <= fpu_d_r;
        end
    end

    // Start pulse is high exactly for the START cycle; retire and error tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_start_r <= 1'b0;
            jobs_done_r <= 16'd0;
            err_op_r    <= 1'b0;
        end else begin
            fpu_start_r <= pop_s && op_is_fpu(head_op_s);
            if (retire_s) begin
                jobs_done_r <= jobs_done_r + 16'd1;
            end
            if (pop_s && !op_is_fpu(head_op_s) && !op_is_noop(head_op_s)) begin
                err_op_r <= 1'b1;
            end
        end
    end

    assign job_ready   = (count_r < CNT_W'(DEPTH));
    assign queue_count = count_r;
    assign busy        = (count_r != {CNT_W{1'b0}}) || (state_r != ST_IDLE);
    assign fpu_op      = fpu_op_r;
    assign fpu_a       = fpu_a_r;
    assign fpu_b       = fpu_b_r;
    assign fpu_c       = fpu_c_r;
    assign fpu_d       = fpu_d_r;
    assign fpu_start   = fpu_start_r;
    assign jobs_done   = jobs_done_r;
    assign err_op      = err_op_r;

endmodule

// File: tb/tb_fpu_job_issuer.sv
// Testbench for fpu_job_issuer: hand-computed vector table, directed
// sequences and randomized traffic against a queue-based reference model.
module tb_fpu_job_issuer;

    localparam int DEPTH = 4;
    localparam int HW    = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          job_valid;
    logic          job_ready;
    logic [5:0]    job_op;
    logic [HW-1:0] job_a, job_b, job_c, job_d;
    logic [5:0]    fpu_op;
    logic [HW-1:0] fpu_a, fpu_b, fpu_c, fpu_d;
    logic          fpu_start;
    logic          fpu_done;
    logic          busy;
    logic [2:0]    queue_count;
    logic [15:0]   jobs_done;
    logic          err_op;

    fpu_job_issuer #(.DEPTH(DEPTH), .HANDLE_W(HW)) dut (
        .clock(clock), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
        .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_d(fpu_d),
        .fpu_start(fpu_start), .fpu_done(fpu_done), .busy(busy),
        .queue_count(queue_count), .jobs_done(jobs_done), .err_op(err_op)
    );

    always #5 clock = ~clock;

    // Reference model: a job queue plus "launch pending" / "in flight" flags.
    typedef struct {
        logic [5:0]    op;
        logic [HW-1:0] a, b, c, d;
    } job_t;

    job_t          mq[$];
    bit            m_launch;
    bit            m_inflight;
    job_t          m_cur;
    int            m_jobs;
    bit            m_err;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit   room;
        job_t j;
        room = (mq.size() < DEPTH);
        if (reset) begin
            mq.delete();
            m_launch   = 1'b0;
            m_inflight = 1'b0;
            m_cur      = '{6'd0, 64'd0, 64'd0, 64'd0, 64'd0};
            m_jobs     = 0;
            m_err      = 1'b0;
            return;
        end
        if (m_launch) begin
            m_launch   = 1'b0;
            m_inflight = 1'b1;
        end else if (m_inflight) begin
            if (fpu_done) begin
                m_jobs     = (m_jobs + 1) % 65536;
                m_inflight = 1'b0;
            end
        end else if (mq.size() > 0) begin
            j     = mq.pop_front();
            m_cur = j;
            if (j.op == 6'd0) m_jobs = (m_jobs + 1) % 65536;
            else if (j.op <= 6'd17) m_launch = 1'b1;
            else m_err = 1'b1;
        end
        if (job_valid && room) mq.push_back('{job_op, job_a, job_b, job_c, job_d});
    endtask

    task automatic check_all();
        chk("fpu_op",      64'(fpu_op),      64'(m_cur.op));
        chk("fpu_a",       fpu_a,            m_cur.a);
        chk("fpu_b",       fpu_b,            m_cur.b);
        chk("fpu_c",       fpu_c,            m_cur.c);
        chk("fpu_d",       fpu_d,            m_cur.d);
        chk("fpu_start",   64'(fpu_start),   64'(m_launch));
        chk("busy",        64'(busy),        64'((mq.size() > 0) || m_launch || m_inflight));
        chk("queue_count", 64'(queue_count), 64'(mq.size()));
        chk("job_ready",   64'(job_ready),   64'(mq.size() < DEPTH));
        chk("jobs_done",   64'(jobs_done),   64'(m_jobs));
        chk("err_op",      64'(err_op),      64'(m_err));
    endtask

    // One clock cycle: drive inputs, step the model at the edge, compare after it.
    task automatic cyc(input bit v, input logic [5:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [63:0] d,
                       input bit done, input bit rst);
        job_valid = v; job_op = op; job_a = a; job_b = b; job_c = c; job_d = d;
        fpu_done = done; reset = rst;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input bit done);
        cyc(1'b0, 6'd0, 64'd0, 64'd0, 64'd0, 64'd0, done, 1'b0);
    endtask

    task automatic push(input logic [5:0] op);
        cyc(1'b1, op, 64'(op) << 8, 64'(op) << 16, 64'(op) << 24, 64'(op) << 32, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         v;
        logic [5:0] op;
        bit         done;
        bit         e_start;
        int         e_qc;
        int         e_dj;
        bit         e_err;
        logic [5:0] e_op;
        bit         e_busy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int         base;
        int         k;
        int         peak;
        bit         saw_full;
        bit         acc;
        logic [5:0] issued[$];
        bit         rv, rd, rr;
        logic [5:0] rop;

        // v, op, done | start, qcount, jobs delta, err, fpu_op, busy
        tbl[0]  = '{1'b1, 6'd0,  1'b0, 1'b0, 1, 0, 1'b0, 6'd1,  1'b1};
        tbl[1]  = '{1'b1, 6'd17, 1'b0, 1'b0, 1, 1, 1'b0, 6'd0,  1'b1};
        tbl[2]  = '{1'b1, 6'd0,  1'b0, 1'b1, 1, 1, 1'b0, 6'd17, 1'b1};
        tbl[3]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1, 1, 1'b0, 6'd17, 1'b1};
        tbl[4]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1, 1, 1'b0, 6'd17, 1'b1};
        tbl[5]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1, 2, 1'b0, 6'd17, 1'b1};
        tbl[6]  = '{1'b0, 6'd0,  1'b0, 1'b0, 0, 3, 1'b0, 6'd0,  1'b0};
        tbl[7]  = '{1'b0, 6'd0,  1'b1, 1'b0, 0, 3, 1'b0, 6'd0,  1'b0};
        tbl[8]  = '{1'b1, 6'd20, 1'b0, 1'b0, 1, 3, 1'b0, 6'd0,  1'b1};
        tbl[9]  = '{1'b1, 6'd11, 1'b0, 1'b0, 1, 3, 1'b1, 6'd20, 1'b1};
        tbl[10] = '{1'b0, 6'd0,  1'b0, 1'b1, 0, 3, 1'b1, 6'd11, 1'b1};
        tbl[11] = '{1'b0, 6'd0,  1'b1, 1'b0, 0, 3, 1'b1, 6'd11, 1'b1};
        tbl[12] = '{1'b0, 6'd0,  1'b0, 1'b0, 0, 3, 1'b1, 6'd11, 1'b1};
        tbl[13] = '{1'b0, 6'd0,  1'b1, 1'b0, 0, 4, 1'b1, 6'd11, 1'b0};

        job_valid = 1'b0; job_op = 6'd0; fpu_done = 1'b0; reset = 1'b1;
        job_a = 64'd0; job_b = 64'd0; job_c = 64'd0; job_d = 64'd0;

        // Reset state.
        cyc(1'b0, 6'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        cyc(1'b0, 6'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        chk("rst_ready", 64'(job_ready), 64'd1);
        chk("rst_busy",  64'(busy),      64'd0);

        // LINEAR_FW: start one cycle after accept, handles held until done.
        cyc(1'b1, 6'd1, 64'h100, 64'h200, 64'h300, 64'h400, 1'b0, 1'b0);
        idle(1'b0);
        chk("lin_start", 64'(fpu_start), 64'd1);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk("lin_hold_a", fpu_a, 64'h100);
            chk("lin_hold_d", fpu_d, 64'h400);
        end
        idle(1'b1);
        chk("lin_jobs", 64'(jobs_done), 64'd1);
        chk("lin_busy", 64'(busy), 64'd0);

        // Table: NOOP/MSE_BW/NOOP, undefined op then RELU_FW, done in IDLE/START.
        for (int i = 0; i < 14; i++) begin
            rop = tbl[i].op;
            cyc(tbl[i].v, rop, 64'(rop), 64'd0, 64'd0, 64'd0, tbl[i].done, 1'b0);
            chk($sformatf("tbl%0d_start", i), 64'(fpu_start),   64'(tbl[i].e_start));
            chk($sformatf("tbl%0d_qc", i),    64'(queue_count), 64'(tbl[i].e_qc));
            chk($sformatf("tbl%0d_jobs", i),  64'(jobs_done),   64'(1 + tbl[i].e_dj));
            chk($sformatf("tbl%0d_err", i),   64'(err_op),      64'(tbl[i].e_err));
            chk($sformatf("tbl%0d_op", i),    64'(fpu_op),      64'(tbl[i].e_op));
            chk($sformatf("tbl%0d_busy", i),  64'(busy),        64'(tbl[i].e_busy));
        end

        // Five jobs against a four-deep FIFO while done is withheld.
        k = 0; peak = 0; saw_full = 1'b0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            acc = job_ready;
            push(6'(k + 1));
            if (acc) k++;
            if (int'(queue_count) > peak) peak = int'(queue_count);
            if (!job_ready) saw_full = 1'b1;
        end
        chk("full_accepted", 64'(k), 64'd5);
        push(6'd9);   // offered while full: must be dropped
        chk("full_peak", 64'(peak), 64'd4);
        chk("full_ready_drop", 64'(saw_full), 64'd1);
        for (int i = 0; i < 200 && int'(jobs_done) != 10; i++) begin
            idle(i % 3 == 2);
            if (fpu_start) issued.push_back(fpu_op);
        end
        chk("full_jobs", 64'(jobs_done), 64'd10);
        chk("full_issued", 64'(issued.size()), 64'd4);
        for (int i = 0; i < issued.size(); i++)
            chk("full_order", 64'(issued[i]), 64'(i + 2));

        // Reset while waiting with two jobs queued.
        push(6'd2);
        idle(1'b0);
        push(6'd3);
        push(6'd4);
        chk("wrst_qc_before", 64'(queue_count), 64'd2);
        cyc(1'b0, 6'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        chk("wrst_qc",    64'(queue_count), 64'd0);
        chk("wrst_op",    64'(fpu_op),      64'd0);
        chk("wrst_err",   64'(err_op),      64'd0);
        idle(1'b1);
        chk("wrst_jobs",  64'(jobs_done),   64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rv  = ($urandom_range(0, 2) != 0);
            rop = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 19)) : 6'($urandom_range(0, 63));
            rd  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 299) == 0);
            cyc(rv, rop, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                {$urandom(), $urandom()}, {$urandom(), $urandom()}, rd, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_job_issuer.md
# fpu_job_issuer

Job-manager-side issuer for the FPU job interface: buffers incoming FPU jobs (op id plus four memory handles a, b, c, d) in a small FIFO and presents them one at a time to the FPU with a start/done handshake. It sits between the job manager's scheduler and the FPU. It holds the op and handle lines stable for the full duration of each FPU operation, retires NOOP jobs locally, and rejects undefined op codes.

## Interface
- DEPTH, 4: job FIFO entries; power of two, at least 2.
- HANDLE_W, 64: width of one packed memory-handle descriptor.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  scheduler offers a job.
- job_ready  out  1  FIFO can accept; equals count < DEPTH.
- job_op  in  6  op id. Encoding: 0 NOOP, 1 LINEAR_FW through 17 MSE_BW, in the enum order. Values 18–63 are undefined.
- job_a, job_b, job_c, job_d  in  HANDLE_W each  packed handle descriptors.
- fpu_op  out  6  op presented to the FPU.
- fpu_a, fpu_b, fpu_c, fpu_d  out  HANDLE_W each  handles presented to the FPU.
- fpu_start  out  1  one-cycle pulse that launches the FPU operation.
- fpu_done  in  1  one-cycle pulse from the FPU marking completion.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- queue_count  out  $clog2(DEPTH)+1  current number of FIFO entries.
- jobs_done  out  16  count of retired jobs (NOOP jobs plus FPU-completed jobs). Wraps modulo 2^16.
- err_op  out  1  sticky flag, set when an undefined op is dequeued.

## Operation
- FIFO:
  - A push occurs on job_valid && job_ready.
  - A pop occurs when the FSM is in IDLE and the FIFO is non-empty.
  - A simultaneous push and pop leaves the count unchanged.
  - There is no bypass path: a job pushed into an empty FIFO is visible to the FSM on the next cycle.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT.
  - IDLE, FIFO non-empty: pop the head entry and register its op into fpu_op and its handles into fpu_a through fpu_d, all on the same edge. The next state depends on the op:
    - Op 1–17: go to START.
    - NOOP: increment jobs_done and stay in IDLE. fpu_start is not pulsed.
    - Undefined op (18–63): set err_op, do not change jobs_done, stay in IDLE.
  - START: drive fpu_start = 1 for exactly this cycle, then go to WAIT unconditionally. fpu_done is ignored during START.
  - WAIT: on fpu_done, increment jobs_done and go to IDLE. Otherwise stay in WAIT indefinitely; there is no timeout.
- fpu_op and fpu_a through fpu_d change only on a pop edge. They hold their values through START and WAIT and after retirement until the next pop.
- fpu_done is ignored in IDLE and START. It counts only in WAIT.
- err_op is cleared only by reset.
- Reset values:
  - FSM returns to IDLE and the FIFO is emptied (queue_count = 0, job_ready = 1).
  - fpu_op = 0 (NOOP), fpu_a through fpu_d = 0, fpu_start = 0.
  - busy = 0, jobs_done = 0, err_op = 0.
- Reset during WAIT abandons the in-flight job: it is not counted, and a later fpu_done is ignored while in IDLE.

## Timing
- A job accepted at edge t into an empty FIFO with the FSM in IDLE:
  - It is popped at edge t+1; fpu_op and the handles are valid from t+1.
  - fpu_start is high for the cycle between edges t+1 and t+2.
- fpu_done sampled at WAIT edge e: jobs_done updates at e and the FSM enters IDLE at e. The next pop happens at e+1, so there is at least one IDLE cycle between consecutive FPU jobs.
- A NOOP or undefined op uses one IDLE cycle per entry, giving back-to-back pops.
- Output registering:
  - job_ready and queue_count are registered-count based and update on the edge after a push or pop.
  - busy is combinational from state and count.
- When the FIFO is full, job_ready = 0 and job_valid is ignored, including in the same cycle as a pop.

## Test plan
- Reset, then push LINEAR_FW (op 1) with a = 0x100, b = 0x200, c = 0x300, d = 0x400 at edge t.
  - Expected: fpu_start high exactly in cycle t+1..t+2; handles stable until fpu_done is pulsed 10 cycles later.
  - Then: jobs_done = 1 and busy = 0.
- Push 5 jobs back-to-back with DEPTH = 4 while the FPU withholds fpu_done.
  - Expected: job_ready drops after the FIFO is full; queue_count peaks at 4.
  - Then: all 5 jobs issue in order as fpu_done pulses arrive; jobs_done = 5.
- Push NOOP, MSE_BW (17), then NOOP.
  - Expected: only one fpu_start pulse; jobs_done = 3; fpu_op reads 0, then 17, then 0.
- Push op 20, then RELU_FW (11).
  - Expected: err_op rises at the pop of op 20 and stays set; RELU_FW still issues; jobs_done = 1.
- Pulse fpu_done while in IDLE and in the START cycle.
  - Expected: jobs_done unchanged; the FSM stays in WAIT until a later pulse.
- Assert reset while in WAIT with 2 jobs queued.
  - Expected: all outputs return to their reset values and queue_count = 0.
  - Then: a following fpu_done does not change jobs_done.
